// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Instruction-phase sequencer for the multi-cycle core. Produces the phase
//   count and one-hot per-phase register enables. Owns run/stop/single-step
//   control from the front-panel buttons and halts on a decoded HALT.
//   Stops and halts are only taken at instruction boundaries. Also counts
//   retired instructions.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset        asynchronous, active-low
//   exec         run/stop button level (synchronised); rising edge acts
//   step         single-step button level (synchronised); rising edge acts
//   halt_req     current instruction is HALT; sampled at the boundary only
//   stall        holds the current phase; combinational into phase_en
//   phase        current phase, registered
//   phase_en     one-hot phase enable (active & !stall & phase==k)
//   running      state is RUN or STEP
//   halted       state is HALTED
//   instr_count  retired instructions, wraps
//   state_dbg    current FSM state encoding, for checkers
//
// Handshake note: this block has no valid/ready channels. Button inputs are
// levels that act on their rising edge; stall is a plain hold qualifier.
module phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step,
  input  logic                  halt_req,
  input  logic                  stall,
  output logic [2:0]            phase,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic                  running,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

  state_t state, state_next;
  logic   exec_q, step_q;
  logic   stop_pending, stop_pending_next;
  logic   exec_rise, step_rise;
  logic   active, advance, boundary;

  assign exec_rise = exec & ~exec_q;
  assign step_rise = step & ~step_q;
  assign active    = (state == S_RUN) || (state == S_STEP);
  assign advance   = active & ~stall;
  // The boundary is the advancing edge out of the last phase; every state
  // change out of RUN/STEP happens here so stops never split an instruction.
  assign boundary  = advance & (phase == LAST_PHASE);

  assign running   = active;
  assign halted    = (state == S_HALTED);
  assign state_dbg = state;

  always_comb begin
    phase_en = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (advance && (phase == 3'(k))) phase_en[k] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        // exec has priority over step when both rise together
        if (exec_rise)      state_next = S_RUN;
        else if (step_rise) state_next = S_STEP;
      end
      S_RUN: begin
        if (boundary) begin
          if (halt_req)                       state_next = S_HALTED;
          else if (stop_pending || exec_rise) state_next = S_IDLE;
        end
      end
      S_STEP: begin
        if (boundary) state_next = halt_req ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (exec_rise) state_next = S_RUN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stop_pending_next = stop_pending;
    if (state_next != state)                stop_pending_next = 1'b0;
    else if (state == S_RUN && exec_rise)   stop_pending_next = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      exec_q       <= 1'b0;
      step_q       <= 1'b0;
      stop_pending <= 1'b0;
      phase        <= 3'd0;
      instr_count  <= '0;
    end else begin
      state        <= state_next;
      exec_q       <= exec;
      step_q       <= step;
      stop_pending <= stop_pending_next;
      if (advance) phase <= boundary ? 3'd0 : phase + 3'd1;
      if (boundary) instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Instruction-phase sequencer for the multi-cycle processor core. It generates the 3-bit phase count and one-hot per-phase register enables that drive fetch/decode/execute/memory/write-back. It owns run/stop/single-step control from the front-panel `exec` and `step` buttons and enters a halted state when the decoder flags a halt instruction. Stops are taken only at instruction boundaries; it also keeps a retired-instruction counter.

## Interface
- `NUM_PHASES`, default 5: phases per instruction (2..8); phase values 0..NUM_PHASES-1.
- `CNT_WIDTH`, default 16: width of the retired-instruction counter.

- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `exec`  in  1  run/stop button level, already synchronised; rising edge acts.
- `step`  in  1  single-step button level, already synchronised; rising edge acts.
- `halt_req`  in  1  decoder flag: the current instruction is HALT; sampled in the last phase only.
- `stall`  in  1  holds the current phase (memory wait); combinational into `phase_en`.
- `phase`  out  3  current phase, registered.
- `phase_en`  out  NUM_PHASES  one-hot enable: bit k = active & !stall & phase==k.
- `running`  out  1  state is RUN or STEP.
- `halted`  out  1  state is HALTED.
- `instr_count`  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH.

## Operation
- Edge detect: `exec_q`/`step_q` registered; `exec_rise = exec & ~exec_q`, likewise `step_rise`. Held buttons act once.
- `advance` = (state RUN or STEP) & !stall. On `advance`, phase increments; from NUM_PHASES-1 it wraps to 0 (the boundary). `instr_count` increments on the boundary.
- `stop_pending` flag: set by `exec_rise` in RUN; cleared on any state change.
- States:
  - IDLE: phase held at 0. `exec_rise` -> RUN; else `step_rise` -> STEP.
  - RUN: on the boundary, if `halt_req` -> HALTED; else if `stop_pending` or `exec_rise` this cycle -> IDLE; else stay in RUN. `step_rise` is ignored.
  - STEP: runs exactly one instruction. On the boundary, `halt_req` -> HALTED, else -> IDLE. `exec_rise` and `step_rise` are ignored.
  - HALTED: phase held at 0. `exec_rise` -> RUN. `step_rise` is ignored.
- Priorities:
  - `exec_rise` and `step_rise` in the same IDLE cycle: exec wins (RUN).
  - `halt_req` and `stop_pending` at the same boundary: HALTED wins.
- `halt_req` is ignored outside the boundary cycle and while stalled.
- `reset` low at any time (mid-phase, stalled, mid-step): immediate return to reset values; no partial count update.

## Timing
- Reset values:
  - state IDLE, `phase`=0, `phase_en`=0, `running`=0, `halted`=0, `instr_count`=0.
  - `exec_q`=0, `step_q`=0, `stop_pending`=0.
- `exec_rise` in IDLE at edge t: `running`=1 after t, `phase_en[0]`=1 in cycle t+1 (if !stall).
- Unstalled instruction: exactly NUM_PHASES cycles, one `phase_en` bit per cycle in order 0..N-1.
- `instr_count` updates on the same edge that wraps phase to 0.
- Stall: each stalled cycle adds one cycle; `phase_en`=0 while stalled; `phase` unchanged.
- Stop/halt latency: state changes on the boundary edge. No `phase_en` is asserted after it. `running` falls on that edge.

## Test plan
- Reset/free run: assert reset low, release, exec 0->1 -> `phase_en` cycles 00001,00010,...,10000 repeatedly; `instr_count` 1 after 5 cycles, 2 after 10.
- Stop at boundary: exec rise while phase=2 in RUN -> phases 3,4 complete; `running` falls on the wrap; `phase`=0; `instr_count` +1; no further enables.
- Single step + stall: step rise from IDLE with stall high for 3 cycles during phase 1 -> 8 cycles total, 5 enables, count +1, then IDLE; a held step does not retrigger.
- Halt: `halt_req`=1 at phase 4 -> `halted`=1, `running`=0 after the wrap; step ignored; exec rise -> RUN from phase 0.
- Simultaneous events: exec and step rise in the same IDLE cycle -> RUN. `halt_req` plus pending stop at the boundary -> HALTED.
- Async reset mid-phase 2 with `instr_count`=0xFFFF: all outputs 0 immediately. Separately, 0xFFFF retiring wraps to 0x0000.
